// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: size codes,
// store FSM states and byte-enable patterns.
package mips_mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   localparam logic [3:0] BE_ALL     = 4'b1111;
   localparam logic [3:0] BE_LO_HALF = 4'b0011;
   localparam logic [3:0] BE_HI_HALF = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      EXC  = 2'd3
   } store_state_e;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational store lane packer: replicates the stored value onto every
// byte lane and selects the lanes to write. Little-endian lane numbering.
// Optional macro: STORE_ALIGN_CHECK_EN enables the misalignment flag; without
// it narrow sizes ignore the low address bits they do not need and the
// reserved size behaves as a word.
module store_lane_pack
   import mips_mem_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic        misalign_raw
);

   // Size decode into replicated data, byte enables and alignment fault.
   always_comb begin
      wdata        = st_data;
      be           = BE_ALL;
      misalign_raw = 1'b0;
      case (st_size)
         SIZE_BYTE: begin
            wdata = {4{st_data[7:0]}};
            be    = 4'b0001 << addr_lo;
         end
         SIZE_HALF: begin
            wdata = {2{st_data[15:0]}};
            be    = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
`ifdef STORE_ALIGN_CHECK_EN
            misalign_raw = addr_lo[0];
`endif
         end
         SIZE_WORD: begin
`ifdef STORE_ALIGN_CHECK_EN
            misalign_raw = (addr_lo != 2'b00);
`endif
         end
         default: begin
`ifdef STORE_ALIGN_CHECK_EN
            misalign_raw = 1'b1;
`endif
         end
      endcase
   end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store unit: accepts one store, holds the packed write on the
// memory port until acknowledged, and reports done / misalign to control.
// Optional macro: STORE_ALIGN_CHECK_EN (misaligned stores take the EXC path).
//
// state | meaning
// IDLE  | waiting for a store; st_ready high unless reset
// REQ   | mem_req high, address/data/enables held until mem_ack
// DONE  | write acknowledged; one-cycle done pulse
// EXC   | misaligned store rejected; one-cycle misalign pulse
module store_unit
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic [1:0]            st_size,
   input  logic [ADDR_W-1:0]     st_addr,
   input  logic [DATA_W-1:0]     st_data,
   output logic                  mem_req,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_be,
   input  logic                  mem_ack,
   output logic                  busy,
   output logic                  done,
   output logic                  misalign
);

   store_state_e        state, state_nxt;
   logic                accept;
   logic [DATA_W-1:0]   pack_wdata;
   logic [DATA_W/8-1:0] pack_be;
   logic                misalign_raw;

   store_lane_pack u_pack (
      .st_size      (st_size),
      .addr_lo      (st_addr[1:0]),
      .st_data      (st_data),
      .wdata        (pack_wdata),
      .be           (pack_be),
      .misalign_raw (misalign_raw)
   );

   assign st_ready = (state == IDLE) & ~reset;

   // State register; reset returns to IDLE and abandons any pending write.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and accept strobe.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (st_valid & st_ready) begin
               accept    = 1'b1;
               state_nxt = misalign_raw ? EXC : REQ;
            end
         end
         REQ:     if (mem_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         EXC:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs follow the next state so they line up with it;
   // the memory port payload is captured only on accept and held after.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_req   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         misalign  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else begin
         mem_req  <= (state_nxt == REQ);
         busy     <= (state_nxt != IDLE);
         done     <= (state_nxt == DONE);
         misalign <= (state_nxt == EXC);
         if (accept) begin
            mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= pack_wdata;
            mem_be    <= pack_be;
         end
      end
   end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with an expected-write scoreboard.
module tb_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [1:0]  st_size;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic        misalign;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   exp_t sb_q[$];
   int   total_cnt = 0;
   int   pass_cnt  = 0;
   int   done_seen = 0;
   int   done_exp  = 0;

   store_unit dut (
      .clk       (clk),
      .reset     (reset),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_size   (st_size),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .busy      (busy),
      .done      (done),
      .misalign  (misalign)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_seen++;

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1);
   end

   // Lane-by-lane reference: a store of n bytes occupies lanes start..start+n-1
   // and every lane carries the byte at its offset modulo n.
   function automatic exp_t model(input logic [1:0] size, input logic [31:0] addr,
                                  input logic [31:0] data);
      exp_t r;
      int nbytes;
      int start;
      nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      if (nbytes == 1)      start = int'(addr[1:0]);
      else if (nbytes == 2) start = addr[1] ? 2 : 0;
      else                  start = 0;
      r.addr = addr & 32'hFFFF_FFFC;
      for (int i = 0; i < 4; i++) begin
         r.wdata[8*i +: 8] = data[8*(i % nbytes) +: 8];
         r.be[i] = (i >= start) && (i < start + nbytes);
      end
      return r;
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready;
      int n = 0;
      while (st_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check1("ready_wait", st_ready, 1'b1);
   endtask

   task automatic compare_payload(input string tag, input exp_t e);
      check32({tag, "_addr"}, mem_addr, e.addr);
      check32({tag, "_wdata"}, mem_wdata, e.wdata);
      check32({tag, "_be"}, {28'b0, mem_be}, {28'b0, e.be});
   endtask

   task automatic pop_exp(output exp_t e);
      if (sb_q.size() == 0) begin
         check1("scoreboard_empty", 1'b1, 1'b0);
         e = '0;
      end else begin
         e = sb_q.pop_front();
      end
   endtask

   task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input int ack_delay);
      exp_t e;
      wait_ready();
      st_valid = 1'b1;
      st_size  = size;
      st_addr  = addr;
      st_data  = data;
      sb_q.push_back(model(size, addr, data));
      tick();
      st_valid = 1'b0;
      st_addr  = 32'hFFFF_FFFF;
      st_data  = 32'h0;
      st_size  = 2'b00;
      check1({tag, "_busy_n1"}, busy, 1'b1);
      check1({tag, "_ready_n1"}, st_ready, 1'b0);
      pop_exp(e);
      for (int d = 0; d <= ack_delay; d++) begin
         check1({tag, "_req"}, mem_req, 1'b1);
         check1({tag, "_nodone"}, done, 1'b0);
         compare_payload(tag, e);
         mem_ack = (d == ack_delay);
         tick();
      end
      mem_ack = 1'b0;
      done_exp++;
      check1({tag, "_done"}, done, 1'b1);
      check1({tag, "_req_off"}, mem_req, 1'b0);
      check1({tag, "_busy_done"}, busy, 1'b1);
      check1({tag, "_ready_done"}, st_ready, 1'b0);
      tick();
      check1({tag, "_done_off"}, done, 1'b0);
      check1({tag, "_busy_off"}, busy, 1'b0);
      check1({tag, "_ready_back"}, st_ready, 1'b1);
   endtask

   initial begin
      exp_t e;
      reset    = 1'b1;
      st_valid = 1'b0;
      st_size  = 2'b00;
      st_addr  = 32'h0;
      st_data  = 32'h0;
      mem_ack  = 1'b0;
      tick(); tick(); tick();

      // reset state
      check1("rst_req", mem_req, 1'b0);
      check32("rst_addr", mem_addr, 32'h0);
      check32("rst_wdata", mem_wdata, 32'h0);
      check32("rst_be", {28'b0, mem_be}, 32'h0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_misalign", misalign, 1'b0);
      check1("rst_ready", st_ready, 1'b0);
      reset = 1'b0;
      #1;
      check1("rst_release_ready", st_ready, 1'b1);

      // basic packing, immediate and delayed acks
      do_store("sb_1003", 2'b00, 32'h0000_1003, 32'hAABB_CC5A, 0);
      do_store("sh_2002", 2'b01, 32'h0000_2002, 32'h1234_BEEF, 3);
      do_store("sw_3000", 2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 0);
      do_store("sb_0000", 2'b00, 32'h0000_0000, 32'h0000_00C3, 1);
      do_store("sh_0004", 2'b01, 32'h0000_0004, 32'h9876_5432, 0);
      do_store("sb_0102", 2'b00, 32'h0000_0102, 32'h1111_1177, 0);

      // misaligned requests
`ifdef STORE_ALIGN_CHECK_EN
      wait_ready();
      st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h0000_3002; st_data = 32'hCAFE_F00D;
      tick();
      st_valid = 1'b0;
      check1("mis_sw_pulse", misalign, 1'b1);
      check1("mis_sw_req", mem_req, 1'b0);
      check1("mis_sw_done", done, 1'b0);
      tick();
      check1("mis_sw_pulse_off", misalign, 1'b0);
      check1("mis_sw_req2", mem_req, 1'b0);
      check1("mis_sw_ready", st_ready, 1'b1);
      st_valid = 1'b1; st_size = 2'b01; st_addr = 32'h0000_3001; st_data = 32'h0000_ABCD;
      tick();
      st_valid = 1'b0;
      check1("mis_sh_pulse", misalign, 1'b1);
      check1("mis_sh_req", mem_req, 1'b0);
      tick();
      check1("mis_sh_pulse_off", misalign, 1'b0);
      check1("mis_sh_ready", st_ready, 1'b1);
      st_valid = 1'b1; st_size = 2'b11; st_addr = 32'h0000_3000; st_data = 32'h0;
      tick();
      st_valid = 1'b0;
      check1("mis_rsvd_pulse", misalign, 1'b1);
      check1("mis_rsvd_req", mem_req, 1'b0);
      tick();
`else
      do_store("sw_3002", 2'b10, 32'h0000_3002, 32'hCAFE_F00D, 0);
      do_store("sh_3001", 2'b01, 32'h0000_3001, 32'h0000_ABCD, 0);
      do_store("rsvd_3003", 2'b11, 32'h0000_3003, 32'h0102_0304, 0);
      check1("no_misalign", misalign, 1'b0);
`endif

      // reset during the second REQ cycle
      wait_ready();
      st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h0000_4000; st_data = 32'h5555_AAAA;
      sb_q.push_back(model(2'b10, 32'h0000_4000, 32'h5555_AAAA));
      tick();
      st_valid = 1'b0;
      check1("rr_req1", mem_req, 1'b1);
      pop_exp(e);
      compare_payload("rr", e);
      tick();
      check1("rr_req2", mem_req, 1'b1);
      reset = 1'b1;
      #1;
      check1("rr_ready_in_reset", st_ready, 1'b0);
      tick();
      check1("rr_req_cleared", mem_req, 1'b0);
      check1("rr_no_done", done, 1'b0);
      check1("rr_busy", busy, 1'b0);
      check32("rr_addr_cleared", mem_addr, 32'h0);
      reset   = 1'b0;
      mem_ack = 1'b1;
      #1;
      check1("rr_ready_after", st_ready, 1'b1);
      tick();
      mem_ack = 1'b0;
      check1("rr_late_ack_done", done, 1'b0);
      check1("rr_late_ack_req", mem_req, 1'b0);
      check1("rr_late_ack_busy", busy, 1'b0);

      // back-to-back with st_valid held high
      wait_ready();
      st_valid = 1'b1; st_size = 2'b00; st_addr = 32'h0000_5001; st_data = 32'h0000_0042;
      sb_q.push_back(model(2'b00, 32'h0000_5001, 32'h0000_0042));
      tick();
      check1("b2b_a_req", mem_req, 1'b1);
      pop_exp(e);
      compare_payload("b2b_a", e);
      mem_ack = 1'b1;
      st_size = 2'b01; st_addr = 32'h0000_5006; st_data = 32'h0000_7E57;
      sb_q.push_back(model(2'b01, 32'h0000_5006, 32'h0000_7E57));
      check1("b2b_ready_n1", st_ready, 1'b0);
      tick();
      mem_ack = 1'b0;
      done_exp++;
      check1("b2b_a_done", done, 1'b1);
      check1("b2b_ready_n2", st_ready, 1'b0);
      tick();
      check1("b2b_ready_n3", st_ready, 1'b1);
      check1("b2b_req_n3", mem_req, 1'b0);
      tick();
      st_valid = 1'b0;
      check1("b2b_b_req", mem_req, 1'b1);
      pop_exp(e);
      compare_payload("b2b_b", e);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      done_exp++;
      check1("b2b_b_done", done, 1'b1);
      tick();
      check1("b2b_ready_end", st_ready, 1'b1);

      tick();
      check32("done_count", done_seen, done_exp);
      check32("scoreboard_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
